// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command-frame decoder family.
// Holds the decoder state encoding, the default command codes and the
// running checksum fold used on write frames.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } state_t;

   localparam logic [7:0] CMD_WR_DEF = 8'h55;
   localparam logic [7:0] CMD_RD_DEF = 8'hAA;

   // Folds one more byte into the running XOR checksum.
   function automatic logic [7:0] chkFold(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

endpackage

// File: rtl/frame_timeout.sv
// Idle-gap watchdog for UART framers. The counter is cleared by 'clr' and
// advances on 'en'. 'expire' is raised on the idle cycle in which the count
// reaches TIMEOUT_CYC-1, so the owner can act on that same cycle. The
// counter saturates so a framer that keeps 'en' high cannot wrap it.
module frame_timeout #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYC - 2);
   localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins, otherwise count idle cycles up to saturation.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != SAT_VAL)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Idle counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = en && !clr && (count_q == LAST_IDLE);

endmodule

// File: rtl/uart_cmd_frame_decode.sv
// UART command-frame decoder. Parses a command byte, a fixed-length payload
// and an optional XOR checksum, forwards payload bytes to the SDRAM write
// FIFO and raises write/read triggers. Bad frames (FIFO overflow, checksum
// mismatch, inter-byte timeout) are reported with wr_abort + frame_err so
// the downstream logic can discard what was already written.
module uart_cmd_frame_decode
   import uart_cmd_pkg::*;
#(
   parameter int         PAYLOAD_LEN = 4,
   parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
   parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
   parameter bit         CHK_EN      = 1'b1,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic       s_clk,
   input  logic       s_rst,
   input  logic       uart_flag,
   input  logic [7:0] uart_data,
   input  logic       wfifo_full,
   output logic       wr_trig,
   output logic       rd_trig,
   output logic       wfifo_wr_en,
   output logic [7:0] wfifo_data,
   output logic       wr_abort,
   output logic       frame_err,
   output logic       busy
);

   // A single-byte payload still needs a one-bit counter to exist.
   localparam int CNT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

   state_t           state_q;
   logic [CNT_W-1:0] byteCnt_q;
   logic [7:0]       chk_q;
   logic             bad_q;

   logic             wrTrig_q;
   logic             rdTrig_q;
   logic             wfifoWrEn_q;
   logic [7:0]       wfifoData_q;
   logic             wrAbort_q;
   logic             frameErr_q;

   logic             timerClr;
   logic             timerEn;
   logic             timerExpire;

   // The watchdog is held at zero while idle and restarted by every byte.
   assign timerClr = (state_q == IDLE) || uart_flag;
   assign timerEn  = !timerClr;

   frame_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk   (s_clk),
      .rst   (s_rst),
      .clr   (timerClr),
      .en    (timerEn),
      .expire(timerExpire)
   );

   // Frame FSM with byte counter, checksum, bad flag and registered pulses.
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         state_q     <= IDLE;
         byteCnt_q   <= '0;
         chk_q       <= '0;
         bad_q       <= 1'b0;
         wrTrig_q    <= 1'b0;
         rdTrig_q    <= 1'b0;
         wfifoWrEn_q <= 1'b0;
         wfifoData_q <= '0;
         wrAbort_q   <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         wrTrig_q    <= 1'b0;
         rdTrig_q    <= 1'b0;
         wfifoWrEn_q <= 1'b0;
         wrAbort_q   <= 1'b0;
         frameErr_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (uart_flag) begin
                  if (uart_data == CMD_WR) begin
                     state_q   <= PAYLOAD;
                     byteCnt_q <= '0;
                     bad_q     <= 1'b0;
                     chk_q     <= CMD_WR;
                  end else if (uart_data == CMD_RD) begin
                     rdTrig_q <= 1'b1;
                  end else begin
                     frameErr_q <= 1'b1;
                  end
               end
            end
            PAYLOAD: begin
               if (uart_flag) begin
                  chk_q     <= chkFold(chk_q, uart_data);
                  byteCnt_q <= byteCnt_q + CNT_W'(1);
                  if (!wfifo_full) begin
                     wfifoWrEn_q <= 1'b1;
                     wfifoData_q <= uart_data;
                  end else begin
                     bad_q <= 1'b1;
                  end
                  if (byteCnt_q == LAST_IDX) begin
                     if (CHK_EN) begin
                        state_q <= CHECK;
                     end else begin
                        state_q <= IDLE;
                        if (bad_q || wfifo_full) begin
                           wrAbort_q  <= 1'b1;
                           frameErr_q <= 1'b1;
                        end else begin
                           wrTrig_q <= 1'b1;
                        end
                     end
                  end
               end else if (timerExpire) begin
                  state_q    <= IDLE;
                  wrAbort_q  <= 1'b1;
                  frameErr_q <= 1'b1;
               end
            end
            CHECK: begin
               if (uart_flag) begin
                  state_q <= IDLE;
                  if ((uart_data == chk_q) && !bad_q) begin
                     wrTrig_q <= 1'b1;
                  end else begin
                     wrAbort_q  <= 1'b1;
                     frameErr_q <= 1'b1;
                  end
               end else if (timerExpire) begin
                  state_q    <= IDLE;
                  wrAbort_q  <= 1'b1;
                  frameErr_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign wr_trig     = wrTrig_q;
   assign rd_trig     = rdTrig_q;
   assign wfifo_wr_en = wfifoWrEn_q;
   assign wfifo_data  = wfifoData_q;
   assign wr_abort    = wrAbort_q;
   assign frame_err   = frameErr_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_frame_decode.sv
// Scoreboard bench for uart_cmd_frame_decode. Two instances share clock and
// reset: dut0 has no checksum byte, dut1 has one; both use a 16-cycle
// inter-byte timeout. Stimulus pushes hand-computed output events (with the
// cycle they must appear in) into per-instance queues; monitors pop them
// whenever an instance raises any output strobe.
module tb_uart_cmd_frame_decode;

   logic       s_clk = 1'b0;
   logic       s_rst = 1'b1;

   logic       flag0 = 1'b0;
   logic [7:0] data0 = 8'h00;
   logic       full0 = 1'b0;
   logic       wrTrig0, rdTrig0, wrEn0, abort0, err0, busy0;
   logic [7:0] wData0;

   logic       flag1 = 1'b0;
   logic [7:0] data1 = 8'h00;
   logic       full1 = 1'b0;
   logic       wrTrig1, rdTrig1, wrEn1, abort1, err1, busy1;
   logic [7:0] wData1;

   uart_cmd_frame_decode #(
      .PAYLOAD_LEN(4), .CMD_WR(8'h55), .CMD_RD(8'hAA), .CHK_EN(1'b0), .TIMEOUT_CYC(16)
   ) dut0 (
      .s_clk(s_clk), .s_rst(s_rst), .uart_flag(flag0), .uart_data(data0),
      .wfifo_full(full0), .wr_trig(wrTrig0), .rd_trig(rdTrig0),
      .wfifo_wr_en(wrEn0), .wfifo_data(wData0), .wr_abort(abort0),
      .frame_err(err0), .busy(busy0)
   );

   uart_cmd_frame_decode #(
      .PAYLOAD_LEN(4), .CMD_WR(8'h55), .CMD_RD(8'hAA), .CHK_EN(1'b1), .TIMEOUT_CYC(16)
   ) dut1 (
      .s_clk(s_clk), .s_rst(s_rst), .uart_flag(flag1), .uart_data(data1),
      .wfifo_full(full1), .wr_trig(wrTrig1), .rd_trig(rdTrig1),
      .wfifo_wr_en(wrEn1), .wfifo_data(wData1), .wr_abort(abort1),
      .frame_err(err1), .busy(busy1)
   );

   always #5 s_clk = ~s_clk;

   int cyc = 0;
   always @(posedge s_clk) cyc <= cyc + 1;

   int nTests = 0;
   int nFail  = 0;
   int lastCyc = 0;

   typedef struct {
      int          cyc;
      logic [12:0] ev;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   // Event word: {wr_en, data, wr_trig, rd_trig, wr_abort, frame_err}
   localparam logic [12:0] EV_TRIG  = 13'b0_00000000_1000;
   localparam logic [12:0] EV_RD    = 13'b0_00000000_0100;
   localparam logic [12:0] EV_ABORT = 13'b0_00000000_0011;
   localparam logic [12:0] EV_ERR   = 13'b0_00000000_0001;

   function automatic logic [12:0] evWr(input logic [7:0] b);
      return {1'b1, b, 4'b0000};
   endfunction

   function automatic logic [12:0] packOut(input logic en, input logic [7:0] d, input logic trig,
                                           input logic rd, input logic ab, input logic err);
      return {en, (en ? d : 8'h00), trig, rd, ab, err};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nTests++;
      if (act !== expv) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic expectEv(input int d, input int c, input logic [12:0] ev);
      exp_t e;
      e.cyc = c;
      e.ev  = ev;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Drives one byte for one cycle, starting at the current falling edge.
   task automatic applyStimulus(input int d, input logic [7:0] b, input logic full);
      lastCyc = cyc;
      if (d == 0) begin flag0 = 1'b1; data0 = b; full0 = full; end
      else        begin flag1 = 1'b1; data1 = b; full1 = full; end
      @(negedge s_clk);
      if (d == 0) begin flag0 = 1'b0; full0 = 1'b0; end
      else        begin flag1 = 1'b0; full1 = 1'b0; end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge s_clk);
   endtask

   // Write frame on dut0 (no checksum); fullIdx marks a payload byte sent while FIFO full.
   task automatic frame0(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [7:0] p3, input int fullIdx, input logic [12:0] endEv);
      logic [7:0]  p [4];
      logic [12:0] ev;
      p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
      applyStimulus(0, 8'h55, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, p[i], (i == fullIdx));
         ev = (i == fullIdx) ? 13'd0 : evWr(p[i]);
         if (i == 3) ev = ev | endEv;
         if (ev != 13'd0) expectEv(0, lastCyc + 1, ev);
      end
   endtask

   // Write frame on dut1 followed by the given checksum byte.
   task automatic frame1(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [7:0] p3, input logic [7:0] chk, input logic [12:0] endEv);
      logic [7:0] p [4];
      p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
      applyStimulus(1, 8'h55, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, p[i], 1'b0);
         expectEv(1, lastCyc + 1, evWr(p[i]));
      end
      applyStimulus(1, chk, 1'b0);
      expectEv(1, lastCyc + 1, endEv);
   endtask

   logic [12:0] v0, v1;
   exp_t        e0, e1;

   // Monitor for dut0: every asserted strobe must match the head of q0.
   always @(negedge s_clk) begin
      v0 = packOut(wrEn0, wData0, wrTrig0, rdTrig0, abort0, err0);
      if (v0 != 13'd0) begin
         nTests++;
         if (q0.size() == 0) begin
            nFail++;
            $display("[TB] FAIL dut0 event: got %h at cycle %0d, expected nothing", v0, cyc);
         end else begin
            e0 = q0.pop_front();
            if ((v0 !== e0.ev) || (cyc != e0.cyc)) begin
               nFail++;
               $display("[TB] FAIL dut0 event: got %h at cycle %0d, expected %h at cycle %0d",
                        v0, cyc, e0.ev, e0.cyc);
            end
         end
      end
      if ((q0.size() > 0) && (q0[0].cyc < cyc)) begin
         e0 = q0.pop_front();
         nTests++;
         nFail++;
         $display("[TB] FAIL dut0 missing event: got none, expected %h at cycle %0d", e0.ev, e0.cyc);
      end
   end

   // Monitor for dut1: every asserted strobe must match the head of q1.
   always @(negedge s_clk) begin
      v1 = packOut(wrEn1, wData1, wrTrig1, rdTrig1, abort1, err1);
      if (v1 != 13'd0) begin
         nTests++;
         if (q1.size() == 0) begin
            nFail++;
            $display("[TB] FAIL dut1 event: got %h at cycle %0d, expected nothing", v1, cyc);
         end else begin
            e1 = q1.pop_front();
            if ((v1 !== e1.ev) || (cyc != e1.cyc)) begin
               nFail++;
               $display("[TB] FAIL dut1 event: got %h at cycle %0d, expected %h at cycle %0d",
                        v1, cyc, e1.ev, e1.cyc);
            end
         end
      end
      if ((q1.size() > 0) && (q1[0].cyc < cyc)) begin
         e1 = q1.pop_front();
         nTests++;
         nFail++;
         $display("[TB] FAIL dut1 missing event: got none, expected %h at cycle %0d", e1.ev, e1.cyc);
      end
   end

   int c11;

   initial begin
      // Reset state of both instances.
      idle(2);
      checkOutput("reset dut0", {wrTrig0, rdTrig0, wrEn0, wData0, abort0, err0, busy0}, 32'd0);
      checkOutput("reset dut1", {wrTrig1, rdTrig1, wrEn1, wData1, abort1, err1, busy1}, 32'd0);
      s_rst = 1'b0;
      idle(2);

      // dut0: plain write frame, trigger together with the last write.
      applyStimulus(0, 8'h55, 1'b0);
      checkOutput("busy0 after CMD_WR", busy0, 1);
      applyStimulus(0, 8'h11, 1'b0); expectEv(0, lastCyc + 1, evWr(8'h11));
      applyStimulus(0, 8'h22, 1'b0); expectEv(0, lastCyc + 1, evWr(8'h22));
      applyStimulus(0, 8'h33, 1'b0); expectEv(0, lastCyc + 1, evWr(8'h33));
      applyStimulus(0, 8'h44, 1'b0); expectEv(0, lastCyc + 1, evWr(8'h44) | EV_TRIG);
      checkOutput("busy0 falls with wr_trig", busy0, 0);
      idle(2);

      // dut0: read command, then an unknown command byte back-to-back.
      applyStimulus(0, 8'hAA, 1'b0); expectEv(0, lastCyc + 1, EV_RD);
      applyStimulus(0, 8'h12, 1'b0); expectEv(0, lastCyc + 1, EV_ERR);
      idle(2);

      // dut0: FIFO full on the second payload byte drops it and aborts.
      frame0(8'hA1, 8'hA2, 8'hA3, 8'hA4, 1, EV_ABORT);
      checkOutput("busy0 falls with wr_abort", busy0, 0);
      idle(2);

      // dut1: good checksum, bad checksum, command-valued payload; back-to-back.
      frame1(8'h01, 8'h02, 8'h03, 8'h04, 8'h51, EV_TRIG);
      frame1(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, EV_ABORT);
      frame1(8'hAA, 8'h55, 8'hAA, 8'hAA, 8'hAA, EV_TRIG);
      checkOutput("busy1 after frames", busy1, 0);
      idle(2);

      // dut1: timeout after one payload byte.
      applyStimulus(1, 8'h55, 1'b0);
      applyStimulus(1, 8'h11, 1'b0);
      c11 = lastCyc;
      expectEv(1, c11 + 1, evWr(8'h11));
      expectEv(1, c11 + 16, EV_ABORT);
      idle(14);
      checkOutput("busy1 before timeout", busy1, 1);
      idle(1);
      checkOutput("busy1 falls on timeout", busy1, 0);
      idle(4);
      frame1(8'h01, 8'h02, 8'h03, 8'h04, 8'h51, EV_TRIG);
      idle(2);

      // dut1: a byte landing exactly on the expiry cycle is accepted.
      applyStimulus(1, 8'h55, 1'b0);
      applyStimulus(1, 8'h11, 1'b0);
      c11 = lastCyc;
      expectEv(1, c11 + 1, evWr(8'h11));
      idle(14);
      applyStimulus(1, 8'h22, 1'b0); expectEv(1, lastCyc + 1, evWr(8'h22));
      checkOutput("expiry-cycle byte timing", lastCyc, c11 + 15);
      applyStimulus(1, 8'h33, 1'b0); expectEv(1, lastCyc + 1, evWr(8'h33));
      applyStimulus(1, 8'h44, 1'b0); expectEv(1, lastCyc + 1, evWr(8'h44));
      applyStimulus(1, 8'h11, 1'b0); expectEv(1, lastCyc + 1, EV_TRIG);
      idle(3);

      // dut0: reset mid-frame clears everything without an abort.
      applyStimulus(0, 8'h55, 1'b0);
      applyStimulus(0, 8'h22, 1'b0); expectEv(0, lastCyc + 1, evWr(8'h22));
      idle(1);
      #1 s_rst = 1'b1;
      #1 checkOutput("mid-frame reset dut0", {wrTrig0, rdTrig0, wrEn0, wData0, abort0, err0, busy0}, 32'd0);
      @(negedge s_clk);
      s_rst = 1'b0;
      idle(1);
      applyStimulus(0, 8'h12, 1'b0); expectEv(0, lastCyc + 1, EV_ERR);
      idle(1);
      frame0(8'h01, 8'h02, 8'h03, 8'h04, -1, EV_TRIG);
      idle(4);

      checkOutput("dut0 queue drained", q0.size(), 0);
      checkOutput("dut1 queue drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
